// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ACCESS, DONE)
//   req_id_e    : requester identity (REQ_CPU, REQ_DBG)
//   LAT_W       : width of the read-latency counter (covers MEM_LAT 1..7)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  localparam int LAT_W = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit data memory port between the CPU control path and the
// debug/boot loader. One transaction at a time: grant in IDLE, drive the
// memory in ACCESS (one cycle for writes, MEM_LAT cycles for reads), then
// pulse the owner's ack in DONE.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request (held stable until cpu_ack)
//   cpu_ack, cpu_rdata       CPU one-cycle completion, held read data
//   dbg_*                    same set for the debug requester
//   mem_raddress/waddress    registered memory addresses
//   mem_datain, mem_wr       registered write data and write strobe
//   mem_dataout              memory read data
//   busy                     high in every state except IDLE
//   grant_dbg                owner of current/last transaction (1 = DBG)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1  // legal range 1..7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [63:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [63:0] dbg_addr,
  input  logic [63:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [63:0] dbg_rdata,
  output logic [63:0] mem_raddress,
  output logic [63:0] mem_waddress,
  output logic [63:0] mem_datain,
  output logic        mem_wr,
  input  logic [63:0] mem_dataout,
  output logic        busy,
  output logic        grant_dbg
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  arb_state_e       state_q, state_d;
  req_id_e          owner_q, owner_d;
  req_id_e          last_q, last_d;
  req_id_e          pick;
  logic             we_q, we_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      raddr_q, raddr_d;
  logic [63:0]      waddr_q, waddr_d;
  logic [63:0]      datain_q, datain_d;
  logic             wr_q, wr_d;
  logic [63:0]      cpu_rdata_q, cpu_rdata_d;
  logic [63:0]      dbg_rdata_q, dbg_rdata_d;

  // On a tie the requester not served last wins; a lone request always wins.
  always_comb begin
    if (cpu_req && dbg_req) begin
      pick = (last_q == REQ_DBG) ? REQ_CPU : REQ_DBG;
    end else if (dbg_req) begin
      pick = REQ_DBG;
    end else begin
      pick = REQ_CPU;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    datain_d    = datain_q;
    wr_d        = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d = pick;
          cnt_d   = LAT_INIT;
          state_d = ACCESS;
          if (pick == REQ_DBG) begin
            we_d     = dbg_we;
            raddr_d  = dbg_addr;
            waddr_d  = dbg_addr;
            datain_d = dbg_wdata;
            wr_d     = dbg_we;
          end else begin
            we_d     = cpu_we;
            raddr_d  = cpu_addr;
            waddr_d  = cpu_addr;
            datain_d = cpu_wdata;
            wr_d     = cpu_we;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          // Read data is valid now; capture it for the owner only.
          state_d = DONE;
          if (owner_q == REQ_DBG) begin
            dbg_rdata_d = mem_dataout;
          end else begin
            cpu_rdata_d = mem_dataout;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset while mem_wr is high does not undo that write: the memory
  // samples the strobe on the same edge that clears it here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= REQ_CPU;
      last_q      <= REQ_DBG;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      datain_q    <= '0;
      wr_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      datain_q    <= datain_d;
      wr_q        <= wr_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_ack      = (state_q == DONE) && (owner_q == REQ_CPU);
  assign dbg_ack      = (state_q == DONE) && (owner_q == REQ_DBG);
  assign cpu_rdata    = cpu_rdata_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign mem_raddress = raddr_q;
  assign mem_waddress = waddr_q;
  assign mem_datain   = datain_q;
  assign mem_wr       = wr_q;
  assign busy         = (state_q != IDLE);
  assign grant_dbg    = (owner_q == REQ_DBG);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance a_* runs with MEM_LAT=1 and
// a behavioural memory array; instance b_* runs with MEM_LAT=3 and a memory
// whose read data is a fixed function of the address, delayed two cycles.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RST;

  logic        a_cpu_req, a_cpu_we, a_cpu_ack;
  logic [63:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic        a_dbg_req, a_dbg_we, a_dbg_ack;
  logic [63:0] a_dbg_addr, a_dbg_wdata, a_dbg_rdata;
  logic [63:0] a_mem_raddress, a_mem_waddress, a_mem_datain, a_mem_dataout;
  logic        a_mem_wr, a_busy, a_grant_dbg;

  logic        b_cpu_req, b_cpu_ack, b_dbg_ack;
  logic [63:0] b_cpu_addr, b_cpu_rdata, b_dbg_rdata;
  logic [63:0] b_mem_raddress, b_mem_waddress, b_mem_datain, b_mem_dataout;
  logic        b_mem_wr, b_busy, b_grant_dbg;

  logic [63:0] mem_a [0:127];
  logic [63:0] b_stage1, b_stage2;

  int checks;
  int errors;

  localparam logic [63:0] WDATA1 = 64'hDEADBEEF_01234567;
  localparam logic [63:0] WDATA2 = 64'h11223344_55667788;
  localparam logic [63:0] B_KEY  = 64'hC3C30000_5A5A0000;

  mem_port_arbiter #(.MEM_LAT(1)) dut_a (
    .CLK(CLK), .RST(RST),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .dbg_req(a_dbg_req), .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr),
    .dbg_wdata(a_dbg_wdata), .dbg_ack(a_dbg_ack), .dbg_rdata(a_dbg_rdata),
    .mem_raddress(a_mem_raddress), .mem_waddress(a_mem_waddress),
    .mem_datain(a_mem_datain), .mem_wr(a_mem_wr), .mem_dataout(a_mem_dataout),
    .busy(a_busy), .grant_dbg(a_grant_dbg)
  );

  mem_port_arbiter #(.MEM_LAT(3)) dut_b (
    .CLK(CLK), .RST(RST),
    .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(b_cpu_addr),
    .cpu_wdata(64'd0), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(64'd0),
    .dbg_wdata(64'd0), .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .mem_raddress(b_mem_raddress), .mem_waddress(b_mem_waddress),
    .mem_datain(b_mem_datain), .mem_wr(b_mem_wr), .mem_dataout(b_mem_dataout),
    .busy(b_busy), .grant_dbg(b_grant_dbg)
  );

  // Clock: 10 time-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory for instance A: synchronous write, combinational read (latency 1).
  always @(posedge CLK) begin
    if (a_mem_wr) mem_a[a_mem_waddress[9:3]] <= a_mem_datain;
  end
  assign a_mem_dataout = mem_a[a_mem_raddress[9:3]];

  // Memory for instance B: data becomes valid three cycles after the address.
  always @(posedge CLK) begin
    b_stage1 <= b_mem_raddress ^ B_KEY;
    b_stage2 <= b_stage1;
  end
  assign b_mem_dataout = b_stage2;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive the request inputs of instance A.
  task automatic applyStimulus(input logic c_req, input logic c_we,
                               input logic [63:0] c_addr, input logic [63:0] c_wdata,
                               input logic d_req, input logic d_we,
                               input logic [63:0] d_addr, input logic [63:0] d_wdata);
    a_cpu_req   = c_req;
    a_cpu_we    = c_we;
    a_cpu_addr  = c_addr;
    a_cpu_wdata = c_wdata;
    a_dbg_req   = d_req;
    a_dbg_we    = d_we;
    a_dbg_addr  = d_addr;
    a_dbg_wdata = d_wdata;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Every output of instance A at its reset value.
  task automatic checkResetA(input string tag);
    checkOutput({tag, " busy"}, 64'(a_busy), 64'd0);
    checkOutput({tag, " cpu_ack"}, 64'(a_cpu_ack), 64'd0);
    checkOutput({tag, " dbg_ack"}, 64'(a_dbg_ack), 64'd0);
    checkOutput({tag, " cpu_rdata"}, a_cpu_rdata, 64'd0);
    checkOutput({tag, " dbg_rdata"}, a_dbg_rdata, 64'd0);
    checkOutput({tag, " mem_raddress"}, a_mem_raddress, 64'd0);
    checkOutput({tag, " mem_waddress"}, a_mem_waddress, 64'd0);
    checkOutput({tag, " mem_datain"}, a_mem_datain, 64'd0);
    checkOutput({tag, " mem_wr"}, 64'(a_mem_wr), 64'd0);
    checkOutput({tag, " grant_dbg"}, 64'(a_grant_dbg), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    b_cpu_req  = 1'b0;
    b_cpu_addr = 64'd0;
    tick();
    tick();
    tick();
    RST = 1'b0;
    $display("[TB] reset values");
    checkResetA("rst");
    checkOutput("rst b_busy", 64'(b_busy), 64'd0);

    // CPU write 0x40: mem_wr for exactly one cycle, ack two cycles later.
    $display("[TB] CPU write");
    applyStimulus(1'b1, 1'b1, 64'h40, WDATA1, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    checkOutput("wr access busy", 64'(a_busy), 64'd1);
    checkOutput("wr access mem_wr", 64'(a_mem_wr), 64'd1);
    checkOutput("wr access waddr", a_mem_waddress, 64'h40);
    checkOutput("wr access datain", a_mem_datain, WDATA1);
    checkOutput("wr access cpu_ack", 64'(a_cpu_ack), 64'd0);
    tick();
    checkOutput("wr done cpu_ack", 64'(a_cpu_ack), 64'd1);
    checkOutput("wr done dbg_ack", 64'(a_dbg_ack), 64'd0);
    checkOutput("wr done mem_wr", 64'(a_mem_wr), 64'd0);
    checkOutput("wr done waddr held", a_mem_waddress, 64'h40);
    checkOutput("wr done grant_dbg", 64'(a_grant_dbg), 64'd0);
    checkOutput("wr memory", mem_a[8], WDATA1);
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    checkOutput("wr idle busy", 64'(a_busy), 64'd0);
    checkOutput("wr idle cpu_ack", 64'(a_cpu_ack), 64'd0);
    checkOutput("wr idle datain held", a_mem_datain, WDATA1);

    // DBG read of the same location with MEM_LAT=1.
    $display("[TB] DBG read");
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 64'h40, 64'd0);
    tick();
    checkOutput("rd access mem_wr", 64'(a_mem_wr), 64'd0);
    checkOutput("rd access raddr", a_mem_raddress, 64'h40);
    checkOutput("rd access dbg_ack", 64'(a_dbg_ack), 64'd0);
    checkOutput("rd access grant_dbg", 64'(a_grant_dbg), 64'd1);
    tick();
    checkOutput("rd done dbg_ack", 64'(a_dbg_ack), 64'd1);
    checkOutput("rd done cpu_ack", 64'(a_cpu_ack), 64'd0);
    checkOutput("rd done dbg_rdata", a_dbg_rdata, WDATA1);
    checkOutput("rd done cpu_rdata", a_cpu_rdata, 64'd0);
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    checkOutput("rd idle dbg_ack", 64'(a_dbg_ack), 64'd0);
    checkOutput("rd idle dbg_rdata held", a_dbg_rdata, WDATA1);

    // MEM_LAT=3 CPU read: busy for four cycles, ack in the fourth.
    $display("[TB] latency-3 read");
    b_cpu_req  = 1'b1;
    b_cpu_addr = 64'h28;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("lat3 busy c%0d", k), 64'(b_busy), 64'd1);
      checkOutput($sformatf("lat3 ack c%0d", k), 64'(b_cpu_ack), (k == 4) ? 64'd1 : 64'd0);
    end
    checkOutput("lat3 rdata", b_cpu_rdata, 64'h28 ^ B_KEY);
    checkOutput("lat3 dbg_ack", 64'(b_dbg_ack), 64'd0);
    b_cpu_req = 1'b0;
    tick();
    checkOutput("lat3 idle busy", 64'(b_busy), 64'd0);
    checkOutput("lat3 idle ack", 64'(b_cpu_ack), 64'd0);

    // Both requesting from reset: strict alternation starting with CPU.
    $display("[TB] round robin");
    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 64'h40, 64'd0, 1'b1, 1'b0, 64'h80, 64'd0);
    tick();
    RST = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      checkOutput($sformatf("rr%0d grant_dbg", t), 64'(a_grant_dbg), 64'(t % 2));
      checkOutput($sformatf("rr%0d busy", t), 64'(a_busy), 64'd1);
      tick();
      checkOutput($sformatf("rr%0d cpu_ack", t), 64'(a_cpu_ack), (t % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rr%0d dbg_ack", t), 64'(a_dbg_ack), (t % 2 == 1) ? 64'd1 : 64'd0);
      if (t == 3) begin
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      end
      tick();
      checkOutput($sformatf("rr%0d idle busy", t), 64'(a_busy), 64'd0);
    end
    checkOutput("rr cpu_rdata", a_cpu_rdata, WDATA1);

    // Reset during the ACCESS cycle of a read: no ack, everything cleared.
    $display("[TB] reset during read");
    applyStimulus(1'b1, 1'b0, 64'h40, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    checkOutput("rstrd access busy", 64'(a_busy), 64'd1);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    checkResetA("rstrd");
    RST = 1'b0;
    tick();
    checkOutput("rstrd after cpu_ack", 64'(a_cpu_ack), 64'd0);
    checkOutput("rstrd after busy", 64'(a_busy), 64'd0);

    // Reset on the edge where a write strobe is high: write still lands.
    $display("[TB] reset during write");
    applyStimulus(1'b1, 1'b1, 64'h100, WDATA2, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    checkOutput("rstwr access mem_wr", 64'(a_mem_wr), 64'd1);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    checkOutput("rstwr memory", mem_a[32], WDATA2);
    checkOutput("rstwr cpu_ack", 64'(a_cpu_ack), 64'd0);
    checkOutput("rstwr mem_wr", 64'(a_mem_wr), 64'd0);
    checkOutput("rstwr busy", 64'(a_busy), 64'd0);
    RST = 1'b0;
    tick();
    checkOutput("rstwr after cpu_ack", 64'(a_cpu_ack), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 64-bit data memory port (Memoria64) between two requesters: the processor control path (CPU) and the debug/boot loader (DBG). It serialises accesses, registers the memory-side address, data and write strobe, counts out the memory read latency, and returns read data with a one-cycle acknowledge. It sits between the state machine/AluOut/B signals and the memory instance in the processor top.

## Interface
- MEM_LAT, 1: memory read latency in cycles, from address presented to Dataout valid; legal 1..7.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU transaction request (level).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  64  byte address.
- cpu_wdata  in  64  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  64  read data, valid while cpu_ack=1, held until next CPU read completes.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as CPU set, for DBG.
- mem_raddress  out  64  memory read address.
- mem_waddress  out  64  memory write address.
- mem_datain  out  64  memory write data.
- mem_wr  out  1  memory write strobe.
- mem_dataout  in  64  memory read data.
- busy  out  1  high in every state except IDLE.
- grant_dbg  out  1  owner of the current/last transaction (0 = CPU, 1 = DBG).

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the requester not served last (round-robin); last-served register resets to DBG, so CPU wins the first tie.
- On grant: latch owner, we, addr, wdata; load mem_raddress = mem_waddress = addr, mem_datain = wdata; mem_wr = we; latency counter = MEM_LAT-1; go ACCESS.
- ACCESS, write: mem_wr high for exactly this one cycle; next state DONE.
- ACCESS, read: mem_wr low; stay until counter reaches 0 (decrement each cycle), then DONE, capturing mem_dataout into the owner's rdata register at that edge.
- DONE: owner's ack = 1 for one cycle; other ack stays 0; update last-served = owner; go IDLE.
- Requester contract: req, we, addr, wdata stable from assertion until ack. req still high in the cycle after ack is a new request.
- The losing requester's req is ignored, not queued; it is served when sampled in a later IDLE.
- Memory-side address/data outputs hold their last values in IDLE and DONE; only mem_wr returns to 0.

## Timing
- Reset values: state IDLE, all acks 0, cpu_rdata/dbg_rdata 0, mem_raddress/mem_waddress/mem_datain 0, mem_wr 0, busy 0, grant_dbg 0, last-served DBG.
- Request sampled in IDLE in cycle n: write ack in cycle n+2; read ack in cycle n+1+MEM_LAT.
- Back-to-back by one requester: minimum 3 cycles per access (IDLE, ACCESS, DONE) at MEM_LAT=1.
- Both requesting continuously: strict alternation CPU, DBG, CPU, ...
- RST during ACCESS or DONE: next state IDLE, no ack issued, rdata not updated. A write whose mem_wr is high at the reset edge is still sampled by the memory; no abort of that write.
- req dropped before ack (contract violation): transaction still completes and acks.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS, DONE), requester id enum (REQ_CPU, REQ_DBG), MEM_LAT width constant (3 bits).
- Single module; the tie-break is one line and needs no sub-module.

## Test plan
- Single CPU write addr 0x40, data 0xDEADBEEF_01234567 → mem_wr high exactly one cycle with those values, cpu_ack in cycle n+2, dbg_ack never high.
- DBG read addr 0x40 after that write, MEM_LAT=1 → dbg_ack in cycle n+2, dbg_rdata = 0xDEADBEEF_01234567, cpu_rdata unchanged.
- MEM_LAT=3 CPU read → cpu_ack in cycle n+4, busy high cycles n+1..n+4.
- Both req high from reset for 4 transactions → grants CPU, DBG, CPU, DBG; grant_dbg = 0,1,0,1.
- RST asserted in ACCESS of a read → no ack, state IDLE next cycle, all outputs at reset values.
- Write during RST-at-ACCESS edge → memory location updated, no cpu_ack.
